// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined register file: clear-engine state
// encodings and the address-width helper.
package pipe_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Address width for a given depth; never narrower than one bit.
  function automatic int unsigned aw_calc(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Sequential clear engine: walks every entry once, one per cycle.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clear_req   start request (ignored while already clearing)
//   clear_busy  high for exactly DEPTH cycles per clear
//   clr_en      zero entry clr_addr at the next edge
//   clr_addr    entry being cleared this cycle
module rf_clear_seq
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // State and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state; last entry returns to idle so busy spans exactly DEPTH cycles.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    clear_busy = 1'b0;
    clr_en     = 1'b0;
    clr_addr   = ptr_q;
    if (state_q == ST_CLEAR) begin
      clear_busy = 1'b1;
      clr_en     = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_regfile.sv
// Multi-port register file with write-to-read bypass, optional zero register,
// per-entry pending (scoreboard) bits and a sequential clear engine.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   we, waddr, wdata        writeback write
//   issue_valid, issue_addr mark destination pending
//   rd_addr / rd_data       NRD packed combinational read ports
//   rd_pending              per-port hazard flag
//   clear_req / clear_busy  start / status of the clear engine
module pipe_regfile
  import pipe_pkg::*;
#(
  parameter  int unsigned DW       = 16,
  parameter  int unsigned DEPTH    = 8,
  parameter  int unsigned NRD      = 2,
  parameter  bit          BYPASS   = 1'b1,
  parameter  bit          ZERO_REG = 1'b0,
  localparam int unsigned AW       = aw_calc(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_pending,
  input  logic              clear_req,
  output logic              clear_busy
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic             clr_en;
  logic [AW-1:0]    clr_addr;
  logic             we_eff;
  logic             issue_eff;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(DEPTH));
  endfunction

  function automatic logic is_zero(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clr_en     (clr_en),
    .clr_addr   (clr_addr)
  );

  // Writes and issues are dropped while clearing and for invalid/zero entries.
  assign we_eff    = we && !clear_busy && addr_ok(waddr) && !is_zero(waddr);
  assign issue_eff = issue_valid && !clear_busy && addr_ok(issue_addr) && !is_zero(issue_addr);

  // Storage and scoreboard; issue is applied last so a new producer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      pend_q <= '0;
    end else begin
      if (clr_en) begin
        mem_q[clr_addr]  <= '0;
        pend_q[clr_addr] <= 1'b0;
      end
      if (we_eff) begin
        mem_q[waddr]  <= wdata;
        pend_q[waddr] <= 1'b0;
      end
      if (issue_eff) pend_q[issue_addr] <= 1'b1;
    end
  end

  // Per-port read mux with optional same-cycle forwarding.
  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0] ra;
    logic [DW-1:0] rdat;
    logic          rpend;
    logic          fwd;

    assign ra  = rd_addr[k*AW +: AW];
    assign fwd = BYPASS && we_eff && (waddr == ra);

    always_comb begin
      rdat  = '0;
      rpend = 1'b0;
      if (addr_ok(ra) && !is_zero(ra)) begin
        rdat  = fwd ? wdata : mem_q[ra];
        rpend = pend_q[ra] && !fwd;
      end
    end

    assign rd_data[k*DW +: DW] = rdat;
    assign rd_pending[k]       = rpend;
  end

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: three instances (bypass, no bypass,
// zero-register with DEPTH=6) share one stimulus stream.
module tb_pipe_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        issue_valid;
  logic [2:0]  issue_addr;
  logic [5:0]  rd_addr;
  logic        clear_req;

  logic [31:0] rd_b, rd_n, rd_z;
  logic [1:0]  pd_b, pd_n, pd_z;
  logic        busy_b, busy_n, busy_z;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_regfile u_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .rd_addr(rd_addr),
    .rd_data(rd_b), .rd_pending(pd_b), .clear_req(clear_req), .clear_busy(busy_b)
  );

  pipe_regfile #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .rd_addr(rd_addr),
    .rd_data(rd_n), .rd_pending(pd_n), .clear_req(clear_req), .clear_busy(busy_n)
  );

  pipe_regfile #(.ZERO_REG(1'b1), .DEPTH(6)) u_zd (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .rd_addr(rd_addr),
    .rd_data(rd_z), .rd_pending(pd_z), .clear_req(clear_req), .clear_busy(busy_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle_in();
    we = 1'b0; waddr = '0; wdata = '0;
    issue_valid = 1'b0; issue_addr = '0; clear_req = 1'b0;
  endtask

  initial begin
    int cb, cn, cz;
    rst_n = 1'b0;
    idle_in();
    set_rd(3'd0, 3'd0);

    // Reset state
    tick();
    check("rst_rd", rd_b, 32'h0);
    check("rst_pend", 32'(pd_b), 32'h0);
    check("rst_busy", 32'(busy_b), 32'h0);
    rst_n = 1'b1;
    tick();

    // Write/read, both ports same entry
    we = 1'b1; waddr = 3'd3; wdata = 16'hA5A5; set_rd(3'd3, 3'd3);
    #1;
    check("byp_wr3_same", rd_b[15:0], 32'hA5A5);
    check("nb_wr3_old", rd_n[15:0], 32'h0);
    tick(); idle_in(); #1;
    check("rd3_p0", rd_b[15:0], 32'hA5A5);
    check("rd3_p1", rd_b[31:16], 32'hA5A5);
    check("nb_rd3", rd_n, 32'hA5A5_A5A5);

    // Bypass vs stored value
    we = 1'b1; waddr = 3'd5; wdata = 16'h1234; set_rd(3'd5, 3'd3);
    #1;
    check("byp_fwd5", rd_b, 32'hA5A5_1234);
    check("nb_old5", rd_n[15:0], 32'h0);
    tick(); idle_in(); #1;
    check("nb_new5", rd_n[15:0], 32'h1234);

    // Scoreboard
    issue_valid = 1'b1; issue_addr = 3'd2; set_rd(3'd2, 3'd2);
    #1;
    check("pend2_before", 32'(pd_b), 32'h0);
    tick(); idle_in(); #1;
    check("pend2_set", 32'(pd_b), 32'h3);
    check("nb_pend2_set", 32'(pd_n), 32'h3);
    we = 1'b1; waddr = 3'd2; wdata = 16'h0007;
    #1;
    check("pend2_masked", 32'(pd_b), 32'h0);
    check("nb_pend2_unmasked", 32'(pd_n), 32'h3);
    tick(); idle_in(); #1;
    check("pend2_clr", 32'(pd_b), 32'h0);
    check("nb_pend2_clr", 32'(pd_n), 32'h0);
    we = 1'b1; waddr = 3'd2; wdata = 16'h0008;
    issue_valid = 1'b1; issue_addr = 3'd2;
    tick(); idle_in(); #1;
    check("pend2_setwins", 32'(pd_b), 32'h3);
    check("rd2_after", rd_b[15:0], 32'h0008);

    // Zero register
    we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF;
    issue_valid = 1'b1; issue_addr = 3'd0; set_rd(3'd0, 3'd0);
    #1;
    check("z_rd0_fwd", rd_z, 32'h0);
    check("byp_rd0_fwd", rd_b[15:0], 32'hFFFF);
    tick(); idle_in(); #1;
    check("z_rd0", rd_z, 32'h0);
    check("z_pend0", 32'(pd_z), 32'h0);
    check("byp_rd0", rd_b[15:0], 32'hFFFF);
    check("byp_pend0", 32'(pd_b), 32'h3);

    // Out-of-range address on DEPTH=6
    we = 1'b1; waddr = 3'd7; wdata = 16'hBEEF; set_rd(3'd7, 3'd6);
    #1;
    check("z_rd7_fwd", rd_z, 32'h0);
    check("byp_rd7_fwd", rd_b[15:0], 32'hBEEF);
    tick(); idle_in(); #1;
    check("z_rd7", rd_z, 32'h0);
    check("byp_rd7", rd_b[15:0], 32'hBEEF);

    // Fill all entries, mark one pending
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 16'h1000 + 16'(i);
      tick();
    end
    idle_in();
    issue_valid = 1'b1; issue_addr = 3'd6;
    tick(); idle_in();
    for (int i = 0; i < 8; i++) begin
      set_rd(3'(i), 3'(7 - i));
      #1;
      check($sformatf("fill_rd%0d", i), rd_b[15:0], 32'h1000 + 32'(i));
      check($sformatf("fill_pd%0d", i), 32'(pd_b[0]), (i == 6) ? 32'h1 : 32'h0);
    end

    // Clear with dropped write/issue and a repeated request mid-clear
    clear_req = 1'b1;
    tick(); idle_in();
    cb = 0; cn = 0; cz = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy_b) cb++;
      if (busy_n) cn++;
      if (busy_z) cz++;
      if (i == 2) begin
        we = 1'b1; waddr = 3'd5; wdata = 16'hDEAD;
        issue_valid = 1'b1; issue_addr = 3'd5; clear_req = 1'b1;
        set_rd(3'd5, 3'd1);
        #1;
        check("clr_nofwd5", rd_b[15:0], 32'h1005);
        check("clr_done1", rd_b[31:16], 32'h0);
        check("clr_pend5", 32'(pd_b[0]), 32'h0);
      end
      tick(); idle_in();
    end
    check("busy_cnt_b", 32'(cb), 32'd8);
    check("busy_cnt_n", 32'(cn), 32'd8);
    check("busy_cnt_z", 32'(cz), 32'd6);
    check("busy_after", 32'(busy_b), 32'h0);
    for (int i = 0; i < 8; i++) begin
      set_rd(3'(i), 3'(i));
      #1;
      check($sformatf("clr_rd%0d", i), rd_b, 32'h0);
      check($sformatf("clr_pd%0d", i), 32'(pd_b), 32'h0);
    end

    // Reset in the third clear cycle
    we = 1'b1; waddr = 3'd7; wdata = 16'h7777;
    issue_valid = 1'b1; issue_addr = 3'd3;
    tick(); idle_in();
    clear_req = 1'b1;
    tick(); idle_in();
    tick();
    tick();
    set_rd(3'd7, 3'd3);
    #1;
    check("mid_clr_rd7", rd_b[15:0], 32'h7777);
    check("mid_clr_pd3", 32'(pd_b[1]), 32'h1);
    check("mid_clr_busy", 32'(busy_b), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_b), 32'h0);
    check("arst_rd", rd_b, 32'h0);
    check("arst_pd", 32'(pd_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("no_resume", 32'(busy_b), 32'h0);
    check("post_rst_rd", rd_b, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
